// File: rtl/jsoc_sys_info_if.sv
// rtl/jsoc_sys_info_if.sv - Avalon-MM style register bus for the system info block
interface jsoc_sys_info_if #(
    parameter int ADDR_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  write;
    logic [31:0]           writedata;
    logic [3:0]            byteenable;
    logic [31:0]           readdata;
    logic                  readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/jsoc_sys_info.sv
// rtl/jsoc_sys_info.sv - system ID, build timestamp, uptime counter, scratch and control registers
module jsoc_sys_info #(
    parameter logic [31:0] SYSTEM_ID    = 32'd26,
    parameter logic [31:0] TIMESTAMP    = 32'd1718117590,
    parameter int          ADDR_WIDTH   = 3,
    parameter logic [31:0] SCRATCH_INIT = 32'h0,
    parameter logic [7:0]  VERSION      = 8'd2
) (
    input logic             clock,
    input logic             reset,
    jsoc_sys_info_if.slave  bus
);
    localparam logic [ADDR_WIDTH-1:0] A_ID        = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_TIMESTAMP = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_UPTIME_LO = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_UPTIME_HI = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_SCRATCH   = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL      = ADDR_WIDTH'(5);
    localparam logic [ADDR_WIDTH-1:0] A_CAPS      = ADDR_WIDTH'(6);

    localparam logic [31:0] CAPS_WORD = {16'h0, 8'(ADDR_WIDTH), VERSION};

    logic [63:0] uptime;
    logic [31:0] uptime_hi_shadow;
    logic [31:0] scratch;
    logic        freeze;
    logic [31:0] readdata_q;
    logic        readdatavalid_q;

    logic [31:0] read_word;
    logic        wr_scratch;
    logic        wr_ctrl;
    logic        clear;

    // CTRL only has bits in byte 0, so only byteenable[0] qualifies its writes.
    always_comb begin
        wr_scratch = bus.write && (bus.address == A_SCRATCH);
        wr_ctrl    = bus.write && (bus.address == A_CTRL) && bus.byteenable[0];
        clear      = wr_ctrl && bus.writedata[0];
    end

    always_comb begin
        read_word = 32'h0;
        case (bus.address)
            A_ID:        read_word = SYSTEM_ID;
            A_TIMESTAMP: read_word = TIMESTAMP;
            A_UPTIME_LO: read_word = uptime[31:0];
            A_UPTIME_HI: read_word = uptime_hi_shadow;
            A_SCRATCH:   read_word = scratch;
            A_CTRL:      read_word = {30'h0, freeze, 1'b0};
            A_CAPS:      read_word = CAPS_WORD;
            default:     read_word = 32'h0;
        endcase
    end

    // Reads sample pre-edge state, so a same-cycle write or clear is seen only by later reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata_q       <= 32'h0;
            readdatavalid_q  <= 1'b0;
            uptime           <= 64'h0;
            uptime_hi_shadow <= 32'h0;
            scratch          <= SCRATCH_INIT;
            freeze           <= 1'b0;
        end else begin
            readdatavalid_q <= bus.read;
            if (bus.read) begin
                readdata_q <= read_word;
                if (bus.address == A_UPTIME_LO) begin
                    uptime_hi_shadow <= uptime[63:32];
                end
            end

            if (clear) begin
                uptime <= 64'h0;
            end else if (!freeze) begin
                uptime <= uptime + 64'd1;
            end

            for (int i = 0; i < 4; i++) begin
                if (wr_scratch && bus.byteenable[i]) begin
                    scratch[8*i +: 8] <= bus.writedata[8*i +: 8];
                end
            end

            if (wr_ctrl) begin
                freeze <= bus.writedata[1];
            end
        end
    end

    assign bus.readdata      = readdata_q;
    assign bus.readdatavalid = readdatavalid_q;
endmodule

// File: tb/tb_jsoc_sys_info.sv
// tb/tb_jsoc_sys_info.sv - scoreboard bench for jsoc_sys_info with a transaction-level model
module tb_jsoc_sys_info;
    localparam int          AW        = 4;
    localparam logic [31:0] SYS_ID    = 32'd26;
    localparam logic [31:0] TS        = 32'd1718117590;
    localparam logic [31:0] SCR_INIT  = 32'h5A5A_0F0F;
    localparam logic [7:0]  VER       = 8'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jsoc_sys_info_if #(.ADDR_WIDTH(AW)) bus ();

    jsoc_sys_info #(
        .SYSTEM_ID(SYS_ID),
        .TIMESTAMP(TS),
        .ADDR_WIDTH(AW),
        .SCRATCH_INIT(SCR_INIT),
        .VERSION(VER)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] data;
        int          addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference state: what the register file should hold after each edge.
    logic [63:0] m_cnt;
    logic [31:0] m_shadow;
    logic [31:0] m_scratch;
    bit          m_freeze;

    function automatic logic [31:0] model_read(input int a);
        case (a)
            0:       return SYS_ID;
            1:       return TS;
            2:       return m_cnt[31:0];
            3:       return m_shadow;
            4:       return m_scratch;
            5:       return m_freeze ? 32'h2 : 32'h0;
            6:       return (AW << 8) | VER;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit rd, input bit wr, input int a,
                         input logic [31:0] wd, input logic [3:0] be);
        bit do_clear;
        rst            = r;
        bus.read       = rd;
        bus.write      = wr;
        bus.address    = AW'(a);
        bus.writedata  = wd;
        bus.byteenable = be;
        if (r) begin
            m_cnt     = 64'h0;
            m_shadow  = 32'h0;
            m_scratch = SCR_INIT;
            m_freeze  = 1'b0;
        end else begin
            if (rd) begin
                exp_q.push_back('{data: model_read(a), addr: a});
                if (a == 2) m_shadow = m_cnt[63:32];
            end
            do_clear = wr && (a == 5) && be[0] && wd[0];
            if (do_clear) m_cnt = 64'h0;
            else if (!m_freeze) m_cnt = m_cnt + 64'd1;
            if (wr && a == 4) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) m_scratch[8*i +: 8] = wd[8*i +: 8];
            end
            if (wr && a == 5 && be[0]) m_freeze = wd[1];
        end
    endtask

    task automatic cyc(input bit r, input bit rd, input bit wr, input int a,
                       input logic [31:0] wd, input logic [3:0] be);
        @(negedge clk);
        drive(r, rd, wr, a, wd, be);
    endtask

    task automatic rd_word(input int a);
        cyc(0, 1, 0, a, 32'h0, 4'h0);
    endtask

    task automatic wr_word(input int a, input logic [31:0] wd, input logic [3:0] be);
        cyc(0, 0, 1, a, wd, be);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 32'h0, 4'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.readdatavalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_readdatavalid: got 1 expected 0 (data %h)", bus.readdata);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("read_word%0d", e.addr), bus.readdata, e.data);
            end
        end
    end

    initial begin
        logic [31:0] v;
        bus.read = 1'b0; bus.write = 1'b0; bus.address = '0;
        bus.writedata = '0; bus.byteenable = '0;

        cyc(1, 1, 0, 4, 32'h0, 4'h0);
        cyc(1, 1, 1, 4, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk); #1;
        chk("reset_readdatavalid", {31'h0, bus.readdatavalid}, 32'h0);
        chk("reset_readdata", bus.readdata, 32'h0);

        rd_word(4);
        rd_word(0);
        rd_word(1);
        idle(1);
        @(posedge clk); #1;
        chk("idle_valid_low", {31'h0, bus.readdatavalid}, 32'h0);
        chk("idle_readdata_hold", bus.readdata, TS);

        // Preload the uptime counter to just below a 32-bit carry.
        @(negedge clk);
        force dut.uptime = 64'h0000_0001_FFFF_FFFF;
        #1;
        release dut.uptime;
        m_cnt = 64'h0000_0001_FFFF_FFFF;
        drive(0, 1, 0, 2, 32'h0, 4'h0);
        rd_word(3);
        rd_word(3);

        wr_word(4, 32'h0, 4'hF);
        wr_word(4, 32'hAABB_CCDD, 4'b0101);
        rd_word(4);
        wr_word(4, 32'h1234_5678, 4'b0000);
        rd_word(4);
        cyc(0, 1, 1, 4, 32'hCAFE_F00D, 4'hF);
        rd_word(4);

        wr_word(5, 32'h2, 4'h1);
        idle(10);
        rd_word(2);
        rd_word(2);
        rd_word(5);
        wr_word(5, 32'h3, 4'h0);
        rd_word(5);
        wr_word(5, 32'h1, 4'h1);
        rd_word(2);
        rd_word(3);
        idle(5);
        cyc(0, 1, 1, 5, 32'h1, 4'h1);
        rd_word(2);

        wr_word(0, 32'hDEAD_BEEF, 4'hF);
        wr_word(6, 32'hDEAD_BEEF, 4'hF);
        wr_word(9, 32'hDEAD_BEEF, 4'hF);
        for (int a = 0; a < 16; a++) rd_word(a);

        for (int i = 0; i < 400; i++) begin
            int a;
            bit rd, wr, r;
            a  = $urandom_range(0, 15);
            rd = ($urandom_range(0, 3) != 0);
            wr = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 99) == 0);
            v  = $urandom;
            if (a == 5 && $urandom_range(0, 3) != 0) v[0] = 1'b0;
            cyc(r, rd, wr, a, v, 4'($urandom_range(0, 15)));
        end

        wr_word(4, 32'h0BAD_0BAD, 4'hF);
        rd_word(4);
        rd_word(2);
        rd_word(0);
        cyc(1, 1, 1, 4, 32'h1111_1111, 4'hF);
        @(posedge clk); #1;
        chk("burst_reset_valid", {31'h0, bus.readdatavalid}, 32'h0);
        chk("burst_reset_readdata", bus.readdata, 32'h0);
        rd_word(4);
        rd_word(9);
        rd_word(3);
        rd_word(6);

        cyc(0, 0, 0, 0, 32'h0, 4'h0);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/jsoc_sys_info.md
JSOC_SYS_INFO -- requirements
Module: jsoc_sys_info

Interface
REQ-001 Parameter SYSTEM_ID, default 32'd26, constant returned at word 0.
REQ-002 Parameter TIMESTAMP, default 32'd1718117590, build time returned at word 1.
REQ-003 Parameter ADDR_WIDTH, default 3, word-address width; legal range 3..8.
REQ-004 Parameter SCRATCH_INIT, default 32'h0, reset value of SCRATCH.
REQ-005 Parameter VERSION, default 8'd2, block revision reported in CAPS.
REQ-006 clock  input  1  sole clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 address  input  ADDR_WIDTH  Avalon-MM word address.
REQ-009 read  input  1  read request, accepted every cycle (no waitrequest).
REQ-010 write  input  1  write request, accepted every cycle.
REQ-011 writedata  input  32  write data.
REQ-012 byteenable  input  4  per-byte write enable; bit n gates writedata[8n+7:8n].
REQ-013 readdata  output  32  registered read data.
REQ-014 readdatavalid  output  1  high for exactly one cycle per accepted read.

Function
REQ-015 Register map SHALL be: 0 ID (RO), 1 TIMESTAMP (RO), 2 UPTIME_LO (RO), 3 UPTIME_HI (RO, shadow), 4 SCRATCH (RW), 5 CTRL (RW), 6 CAPS (RO), 7 and above read 32'h0.
REQ-016 Read latency SHALL be exactly 1 cycle: read high at edge N -> readdata valid and readdatavalid=1 at edge N+1; back-to-back reads every cycle SHALL be supported.
REQ-017 readdatavalid SHALL be 0 in any cycle not following an accepted read; readdata SHALL hold its last value when readdatavalid=0.
REQ-018 Uptime SHALL be a 64-bit free-running counter incrementing by 1 per clock when CTRL.FREEZE=0, wrapping from 2^64-1 to 0.
REQ-019 A read of UPTIME_LO SHALL return counter[31:0] and, in the same edge, latch counter[63:32] into the HI shadow; reads of word 3 SHALL return the shadow, never the live upper half.
REQ-020 CTRL bit0 CLEAR SHALL be write-1-to-pulse: counter becomes 0 on the following edge; bit reads as 0.
REQ-021 CTRL bit1 FREEZE SHALL be a stored RW bit; when 1 the counter holds; CTRL[31:2] read 0 and ignore writes.
REQ-022 CLEAR and increment in the same cycle: counter SHALL be 0 next cycle (clear wins); CLEAR with FREEZE=1 still clears.
REQ-023 SCRATCH SHALL update only enabled bytes; byteenable=4'b0000 SHALL leave it unchanged.
REQ-024 CTRL writes SHALL honour byteenable[0] only; byteenable[0]=0 means no CLEAR and no FREEZE change.
REQ-025 Writes to RO words or unmapped words SHALL have no effect.
REQ-026 Simultaneous read and write to the same word: read SHALL return the pre-write value; write takes effect at that edge.
REQ-027 Read of UPTIME_LO in the same cycle as CLEAR SHALL return pre-clear low word and shadow the pre-clear high word.
REQ-028 CAPS SHALL read {16'h0, ADDR_WIDTH[7:0], VERSION}.
REQ-029 read and write both low SHALL leave all state except the counter unchanged.

Reset
REQ-030 On reset high at an edge: readdata=0, readdatavalid=0, counter=0, HI shadow=0, SCRATCH=SCRATCH_INIT, FREEZE=0.
REQ-031 Reset SHALL override any read or write in the same cycle; a read accepted the cycle before reset SHALL NOT produce readdatavalid after reset.
REQ-032 Counter SHALL begin incrementing on the first edge after reset deasserts.

Verification
REQ-033 After reset, read word 0 then word 1 back-to-back -> readdata 26 then 1718117590 on consecutive cycles, readdatavalid high both cycles.
REQ-034 Preload counter to 64'h0000_0001_FFFF_FFFF (via N cycles or force), read word 2 then word 3 -> 32'hFFFF_FFFF then 32'h1 despite carry between reads.
REQ-035 Write SCRATCH 32'hAABBCCDD with byteenable 4'b0101 over 0 -> read returns 32'h00BB00DD.
REQ-036 Write CTRL=2 (freeze), wait 10 cycles, read words 2 twice -> identical values; write CTRL=1 -> next UPTIME_LO read returns 0.
REQ-037 Assert reset during a read burst -> readdatavalid 0 from reset edge, SCRATCH returns SCRATCH_INIT, word 9 (ADDR_WIDTH=4) reads 0.
